// File: rtl/spi_dopi_pkg.sv
// Shared types and command constants for the octal-SPI DTR flash responder.
// Optional ECS flagging in the top is enabled by SPI_DOPI_RESP_ECS_EN.
package spi_dopi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        OP_READ,
        OP_RDID,
        OP_RDSR
    } op_t;

    localparam logic [7:0] OPC_8DTRD = 8'hEE;
    localparam logic [7:0] OPC_RDID  = 8'h9F;
    localparam logic [7:0] OPC_RDSR  = 8'h05;
    localparam logic [7:0] RDSR_VAL  = 8'h00;

    // A command is accepted only for a known opcode followed by its complement.
    function automatic logic cmd_ok(input logic [7:0] opc, input logic [7:0] cmp);
        logic known;
        known = (opc == OPC_8DTRD) || (opc == OPC_RDID) || (opc == OPC_RDSR);
        return known && (cmp == ~opc);
    endfunction

    function automatic op_t op_of(input logic [7:0] opc);
        op_t op;
        op = OP_RDSR;
        if (opc == OPC_8DTRD)
            op = OP_READ;
        else if (opc == OPC_RDID)
            op = OP_RDID;
        return op;
    endfunction

endpackage

// File: rtl/spi_dopi_edge_sync.sv
// Two-flop synchronizers for the host bus plus SCLK edge and CS# fall strobes.
// Strobes are one refclk wide and line up with the synchronized data.
module spi_dopi_edge_sync (
    input  logic       refclk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic [7:0] dq_i,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       cs_fall,
    output logic       cs_n_s,
    output logic [7:0] dq_s
);

    logic       sclk_m;
    logic       sclk_s;
    logic       sclk_p;
    logic       cs_m;
    logic       cs_p;
    logic [7:0] dq_m;

    // CS# resets to deasserted so release of reset never looks like a select.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sclk_m <= 1'b0;
            sclk_s <= 1'b0;
            sclk_p <= 1'b0;
            cs_m   <= 1'b1;
            cs_n_s <= 1'b1;
            cs_p   <= 1'b1;
            dq_m   <= '0;
            dq_s   <= '0;
        end else begin
            sclk_m <= sclk;
            sclk_s <= sclk_m;
            sclk_p <= sclk_s;
            cs_m   <= cs_n;
            cs_n_s <= cs_m;
            cs_p   <= cs_n_s;
            dq_m   <= dq_i;
            dq_s   <= dq_m;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_p;
    assign sclk_fall = ~sclk_s & sclk_p;
    assign cs_fall   = ~cs_n_s & cs_p;

endmodule

// File: rtl/spi_dopi_responder.sv
// Octal-SPI DTR (DOPI) flash target serving 8DTRD/RDID/RDSR from word memory.
// Define SPI_DOPI_RESP_ECS_EN to add mem_ecc_err input and ecs_n output.
module spi_dopi_responder
    import spi_dopi_pkg::*;
#(
    parameter int          ADDR_W  = 24,
    parameter int          DUMMY   = 20,
    parameter logic [31:0] ID_CODE = 32'hC2803B00
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic [7:0]        dq_i,
    output logic [7:0]        dq_o,
    output logic              dq_oe,
    output logic              dqs_o,
    output logic              dqs_oe,
    output logic              mem_re,
    output logic [ADDR_W-2:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic              cmd_err,
    output logic              busy
`ifdef SPI_DOPI_RESP_ECS_EN
    ,
    input  logic              mem_ecc_err,
    output logic              ecs_n
`endif
);

    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_fall;
    logic              cs_n_s;
    logic [7:0]        dq_s;

    state_t            state_q;
    state_t            state_d;
    op_t               op_q;
    op_t               op_d;
    logic [4:0]        cnt_q;
    logic [4:0]        cnt_d;
    logic [7:0]        opc_q;
    logic [7:0]        opc_d;
    logic [ADDR_W-9:0] asr_q;
    logic [ADDR_W-9:0] asr_d;
    logic [1:0]        bidx_q;
    logic [1:0]        bidx_d;
    logic [15:0]       word_q;
    logic              cap_q;
    logic [ADDR_W-2:0] maddr_d;
    logic [7:0]        dq_d;
    logic              dq_oe_d;
    logic              dqs_d;
    logic              dqs_oe_d;
    logic              re_d;
    logic              err_d;
    logic              data_rise;
    logic              data_fall;
    logic [7:0]        id_byte;
    logic [7:0]        tx_byte;

    spi_dopi_edge_sync u_sync (
        .refclk    (refclk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .dq_i      (dq_i),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_n_s    (cs_n_s),
        .dq_s      (dq_s)
    );

    // The rise that ends the dummy phase is itself the first data beat.
    assign data_rise = sclk_rise & ((state_q == ST_DATA) |
                       ((state_q == ST_DUMMY) & (cnt_q == 5'(DUMMY))));
    assign data_fall = sclk_fall & (state_q == ST_DATA);
    assign id_byte   = ID_CODE[{~bidx_q, 3'b000} +: 8];

    always_comb begin
        tx_byte = RDSR_VAL;
        case (op_q)
            OP_READ: tx_byte = sclk_rise ? word_q[7:0] : word_q[15:8];
            OP_RDID: tx_byte = id_byte;
            default: tx_byte = RDSR_VAL;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        opc_d    = opc_q;
        asr_d    = asr_q;
        bidx_d   = bidx_q;
        maddr_d  = mem_addr;
        dq_d     = dq_o;
        dqs_d    = dqs_o;
        dq_oe_d  = 1'b0;
        dqs_oe_d = 1'b0;
        re_d     = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                    bidx_d  = '0;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    opc_d = dq_s;
                end else if (sclk_fall) begin
                    if (cmd_ok(opc_q, dq_s)) begin
                        op_d    = op_of(opc_q);
                        state_d = ST_ADDR;
                        cnt_d   = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IGNORE;
                    end
                end
            end
            ST_ADDR: begin
                if (sclk_rise | sclk_fall) begin
                    asr_d = (ADDR_W-8)'({asr_q, dq_s});
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd3) begin
                        state_d = ST_DUMMY;
                        cnt_d   = '0;
                        if (op_q == OP_READ) begin
                            maddr_d = {asr_q, dq_s[7:1]};
                            re_d    = 1'b1;
                        end
                    end
                end
            end
            ST_DUMMY: begin
                dqs_oe_d = 1'b1;
                dqs_d    = 1'b0;
                if (data_rise) begin
                    state_d = ST_DATA;
                    dq_oe_d = 1'b1;
                    dq_d    = tx_byte;
                    dqs_d   = 1'b1;
                    bidx_d  = bidx_q + 2'd1;
                end else if (sclk_rise) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DATA: begin
                dq_oe_d  = 1'b1;
                dqs_oe_d = 1'b1;
                if (data_rise) begin
                    dq_d   = tx_byte;
                    dqs_d  = 1'b1;
                    bidx_d = bidx_q + 2'd1;
                end else if (data_fall) begin
                    dq_d   = tx_byte;
                    dqs_d  = 1'b0;
                    bidx_d = bidx_q + 2'd1;
                    if (op_q == OP_READ) begin
                        maddr_d = mem_addr + (ADDR_W-1)'(1);
                        re_d    = 1'b1;
                    end
                end
            end
            ST_IGNORE: begin
                state_d = ST_IGNORE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (cs_n_s) begin
            state_d  = ST_IDLE;
            dq_d     = '0;
            dqs_d    = 1'b0;
            dq_oe_d  = 1'b0;
            dqs_oe_d = 1'b0;
            re_d     = 1'b0;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_RDSR;
            cnt_q    <= '0;
            opc_q    <= '0;
            asr_q    <= '0;
            bidx_q   <= '0;
            word_q   <= '0;
            cap_q    <= 1'b0;
            mem_addr <= '0;
            mem_re   <= 1'b0;
            dq_o     <= '0;
            dq_oe    <= 1'b0;
            dqs_o    <= 1'b0;
            dqs_oe   <= 1'b0;
            cmd_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            opc_q    <= opc_d;
            asr_q    <= asr_d;
            bidx_q   <= bidx_d;
            cap_q    <= mem_re;
            if (cap_q)
                word_q <= mem_rdata;
            mem_addr <= maddr_d;
            mem_re   <= re_d;
            dq_o     <= dq_d;
            dq_oe    <= dq_oe_d;
            dqs_o    <= dqs_d;
            dqs_oe   <= dqs_oe_d;
            cmd_err  <= err_d;
            busy     <= (state_d != ST_IDLE);
        end
    end

`ifdef SPI_DOPI_RESP_ECS_EN
    logic ecc_q;

    // The flag follows its word and is shown from the rise that presents it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            ecc_q <= 1'b0;
            ecs_n <= 1'b1;
        end else begin
            if (cap_q)
                ecc_q <= mem_ecc_err;
            if (cs_n_s)
                ecs_n <= 1'b1;
            else if (data_rise)
                ecs_n <= ~(ecc_q & (op_q == OP_READ));
        end
    end
`endif

endmodule
